// File: rtl/cim_pkg.sv
// Constants and helpers shared between the global controller and the bit-serial datapath.
package cim_pkg;

    localparam int unsigned SEL_W     = 6;
    localparam int unsigned LIMIT_12B = 11;
    localparam int unsigned LIMIT_24B = 23;

    // Index of the last (MSB) bit-plane for the selected input width.
    function automatic logic [SEL_W-1:0] step_limit(input logic inwidth);
        return inwidth ? SEL_W'(LIMIT_24B) : SEL_W'(LIMIT_12B);
    endfunction

endpackage

// File: rtl/res_fifo2.sv
// Two-entry shift-style result FIFO; the head lives in a flop driving dout directly.
module res_fifo2 #(
    parameter int unsigned W = 40
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    logic [W-1:0] mem1;
    logic         vld0;
    logic         vld1;
    logic         do_pop_c;

    assign do_pop_c = pop && vld0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout <= '0;
            mem1 <= '0;
            vld0 <= 1'b0;
            vld1 <= 1'b0;
        end else if (do_pop_c && push) begin
            // Simultaneous pop and push: occupancy unchanged.
            if (vld1) begin
                dout <= mem1;
                mem1 <= din;
            end else begin
                dout <= din;
            end
        end else if (do_pop_c) begin
            dout <= mem1;
            vld0 <= vld1;
            vld1 <= 1'b0;
        end else if (push) begin
            if (!vld0) begin
                dout <= din;
                vld0 <= 1'b1;
            end else if (!vld1) begin
                mem1 <= din;
                vld1 <= 1'b1;
            end
        end
    end

    assign full  = vld1;
    assign empty = !vld0;

endmodule

// File: rtl/bs_accum.sv
// Bit-serial shift-accumulator: sums 2^sel-weighted plane partial sums and queues each finished result.
module bs_accum
    import cim_pkg::*;
#(
    parameter int unsigned PSUM_W = 16,
    parameter int unsigned OUT_W  = PSUM_W + 24,
    parameter int unsigned FIFO_D = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     st,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sus,
    input  logic                     inwidth,
    input  logic                     in_signed,
    input  logic signed [PSUM_W-1:0] psum,
    output logic signed [OUT_W-1:0]  res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     ovf_err,
    output logic                     seq_err,
    input  logic                     clr_err
);

    localparam int unsigned EXT_W = OUT_W - PSUM_W;

    if (FIFO_D != 2) begin : g_depth_check
        $error("bs_accum: output FIFO is fixed at two entries");
    end

    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] acc_d;
    logic [SEL_W-1:0]        exp_sel_q;
    logic [SEL_W-1:0]        exp_sel_d;
    logic                    busy_d;
    logic                    ovf_d;
    logic                    seq_d;

    logic [SEL_W-1:0]        limit_c;
    logic signed [OUT_W-1:0] ext_c;
    logic signed [OUT_W-1:0] shifted_c;
    logic signed [OUT_W-1:0] term_c;
    logic signed [OUT_W-1:0] sum_c;
    logic                    push_c;
    logic                    seq_ev_c;
    logic                    ovf_ev_c;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OUT_W-1:0]        fifo_dout;

    // Term generation: sign-extend, weight by plane, negate the MSB plane of signed inputs.
    always_comb begin
        limit_c   = step_limit(inwidth);
        ext_c     = {{EXT_W{psum[PSUM_W-1]}}, psum};
        shifted_c = ext_c << sel;
        term_c    = (in_signed && (sel == limit_c)) ? -shifted_c : shifted_c;
        sum_c     = (busy ? acc_q : OUT_W'(0)) + term_c;
    end

    // Step sequencing, result push and error events.
    always_comb begin
        acc_d     = acc_q;
        busy_d    = busy;
        exp_sel_d = exp_sel_q;
        push_c    = 1'b0;
        seq_ev_c  = 1'b0;
        if (!st) begin
            seq_ev_c = (sel != exp_sel_q) || (sel > limit_c);
            if (sus) begin
                push_c    = 1'b1;
                busy_d    = 1'b0;
                exp_sel_d = '0;
                acc_d     = '0;
            end else begin
                acc_d     = sum_c;
                busy_d    = 1'b1;
                exp_sel_d = exp_sel_q + SEL_W'(1);
            end
        end else if (busy) begin
            // Controller stopped without a final step: drop the partial result.
            seq_ev_c  = 1'b1;
            busy_d    = 1'b0;
            exp_sel_d = '0;
            acc_d     = '0;
        end
        // A full FIFO always has a head, so res_ready alone means a pop happens.
        ovf_ev_c = push_c && fifo_full && !res_ready;
        ovf_d    = ovf_ev_c || (ovf_err && !clr_err);
        seq_d    = seq_ev_c || (seq_err && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q     <= '0;
            busy      <= 1'b0;
            exp_sel_q <= '0;
            ovf_err   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            busy      <= busy_d;
            exp_sel_q <= exp_sel_d;
            ovf_err   <= ovf_d;
            seq_err   <= seq_d;
        end
    end

    res_fifo2 #(
        .W (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_c),
        .din   (sum_c),
        .full  (fifo_full),
        .pop   (res_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign res_data  = fifo_dout;
    assign res_valid = !fifo_empty;

endmodule

// File: tb/tb_bs_accum.sv
// Scoreboard bench for bs_accum: directed bit-plane sequences with hand-computed results.
module tb_bs_accum;

    localparam int unsigned PSUM_W = 16;
    localparam int unsigned OUT_W  = 40;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     st;
    logic [5:0]               sel;
    logic                     sus;
    logic                     inwidth;
    logic                     in_signed;
    logic signed [PSUM_W-1:0] psum;
    logic signed [OUT_W-1:0]  res_data;
    logic                     res_valid;
    logic                     res_ready;
    logic                     busy;
    logic                     ovf_err;
    logic                     seq_err;
    logic                     clr_err;

    int errors = 0;
    int checks = 0;

    logic signed [OUT_W-1:0] sb[$];
    logic signed [OUT_W-1:0] exp_head;
    logic signed [OUT_W-1:0] prev_data;
    logic                    held = 1'b0;
    logic signed [PSUM_W-1:0] ps[24];

    bs_accum dut (
        .clk       (clk),
        .rstn      (rstn),
        .st        (st),
        .sel       (sel),
        .sus       (sus),
        .inwidth   (inwidth),
        .in_signed (in_signed),
        .psum      (psum),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .ovf_err   (ovf_err),
        .seq_err   (seq_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected result; stalled heads must hold.
    always @(negedge clk) begin
        if (!rstn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, prev_data);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", res_data);
                end else begin
                    exp_head = sb.pop_front();
                    check("res_data", res_data, exp_head);
                end
            end
            held      = res_valid && !res_ready;
            prev_data = res_data;
        end
    end

    task automatic step(input logic s_st, input logic [5:0] s_sel, input logic s_sus,
                        input logic signed [PSUM_W-1:0] s_psum);
        st   = s_st;
        sel  = s_sel;
        sus  = s_sus;
        psum = s_psum;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        st   = 1'b1;
        sus  = 1'b0;
        sel  = '0;
        psum = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic signed [PSUM_W-1:0] v);
        foreach (ps[i]) ps[i] = v;
    endtask

    // One complete accumulation over all planes of the chosen width, using ps[].
    task automatic run_op(input logic w, input logic sgn, input logic signed [OUT_W-1:0] exp,
                          input logic expect_push);
        int lim;
        lim       = w ? 23 : 11;
        inwidth   = w;
        in_signed = sgn;
        if (expect_push) sb.push_back(exp);
        for (int i = 0; i <= lim; i++) begin
            step(1'b0, 6'(i), i == lim, ps[i]);
            if (i == lim / 2) check("busy_mid", busy, 1);
        end
        st  = 1'b1;
        sus = 1'b0;
        check("busy_end", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rstn      = 1'b0;
        st        = 1'b1;
        sel       = '0;
        sus       = 1'b0;
        inwidth   = 1'b0;
        in_signed = 1'b0;
        psum      = '0;
        res_ready = 1'b1;
        clr_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_seq", seq_err, 0);
        rstn = 1'b1;
        idle(1);

        // 12b unsigned, psum=1 everywhere: 4095, one-cycle valid pulse.
        fill(16'sd1);
        run_op(1'b0, 1'b0, 40'sd4095, 1'b1);
        check("pulse_on", res_valid, 1);
        idle(1);
        check("pulse_off", res_valid, 0);
        check("seq_clean", seq_err, 0);

        // 12b signed, planes 0 and 11: 1 - 2048.
        fill(16'sd0);
        ps[0]  = 16'sd1;
        ps[11] = 16'sd1;
        run_op(1'b0, 1'b1, -40'sd2047, 1'b1);
        idle(2);

        // 24b signed, -3 on the MSB plane: +3*2^23.
        fill(16'sd0);
        ps[23] = -16'sd3;
        run_op(1'b1, 1'b1, 40'sd25165824, 1'b1);
        idle(2);

        // 24b unsigned, 0x7FFF everywhere: 0x7FFF*(2^24-1) without wrap.
        fill(16'sh7FFF);
        run_op(1'b1, 1'b0, 40'sd549739003905, 1'b1);
        idle(2);
        check("seq_clean_24", seq_err, 0);

        // Stalled downstream: two results held in order, third dropped.
        res_ready = 1'b0;
        fill(16'sd1);
        run_op(1'b0, 1'b0, 40'sd4095, 1'b1);
        fill(16'sd2);
        run_op(1'b0, 1'b0, 40'sd8190, 1'b1);
        check("ovf_before", ovf_err, 0);
        fill(16'sd3);
        run_op(1'b0, 1'b0, 40'sd12285, 1'b0);
        check("ovf_set", ovf_err, 1);
        check("head_first", res_data, 4095);
        res_ready = 1'b1;
        idle(3);
        check("drained", res_valid, 0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("ovf_clr", ovf_err, 0);

        // Full FIFO with a pop in the sus cycle: no drop.
        res_ready = 1'b0;
        fill(16'sd1);
        run_op(1'b0, 1'b0, 40'sd4095, 1'b1);
        fill(16'sd2);
        run_op(1'b0, 1'b0, 40'sd8190, 1'b1);
        inwidth   = 1'b0;
        in_signed = 1'b0;
        sb.push_back(40'sd12285);
        for (int i = 0; i <= 11; i++) begin
            if (i == 11) res_ready = 1'b1;
            step(1'b0, 6'(i), i == 11, 16'sd3);
        end
        res_ready = 1'b0;
        st        = 1'b1;
        sus       = 1'b0;
        check("ovf_none", ovf_err, 0);
        check("head_second", res_data, 8190);
        idle(2);
        check("still_valid", res_valid, 1);
        res_ready = 1'b1;
        idle(3);
        check("drained2", res_valid, 0);

        // sus while stopped is ignored.
        step(1'b1, 6'd0, 1'b1, 16'sd5);
        idle(1);
        check("sus_idle_valid", res_valid, 0);
        check("sus_idle_seq", seq_err, 0);

        // Abort with clr_err in the same cycle: the new error wins.
        step(1'b0, 6'd0, 1'b0, 16'sd1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("abort_seq", seq_err, 1);
        check("abort_busy", busy, 0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("seq_clr", seq_err, 0);

        // Reset mid-accumulation, then an op that skips plane 4.
        inwidth   = 1'b0;
        in_signed = 1'b0;
        for (int i = 0; i <= 4; i++) step(1'b0, 6'(i), 1'b0, 16'sd1);
        rstn = 1'b0;
        step(1'b0, 6'd5, 1'b0, 16'sd1);
        rstn = 1'b1;
        st   = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        idle(1);
        sb.push_back(40'sd4079);
        for (int i = 0; i <= 11; i++) begin
            if (i != 4) step(1'b0, 6'(i), i == 11, 16'sd1);
        end
        st  = 1'b1;
        sus = 1'b0;
        check("skip_seq", seq_err, 1);
        check("skip_valid", res_valid, 1);
        idle(3);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
